cmd_seq_checker: RTL

- Self-checking command sequencer for Knight tour system-level benches; the generalised successor of the single-command send/wait/ack flow.
- Holds up to DEPTH 16-bit commands, issues them in order to RemoteComm, and waits for each command to be sent and acknowledged.
- Checks each response byte against POS_ACK under a per-command timeout.
- Reports pass/fail, error cause and failing command index, so benches run whole tours instead of hand-sequenced tasks.

---
 rtl/cmd_seq_checker.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/cmd_seq_checker.sv
`timescale 1ns/1ps
// cmd_seq_checker: queues up to DEPTH 16-bit commands, issues them one by one
// to RemoteComm, waits for "sent" and a response byte for each, and reports
// pass/fail with an error cause and the index of the failing command.
//
// Handshake semantics: send_cmd is a single-cycle strobe qualifying cmd; the
// responder answers with single-cycle cmd_sent and resp_rdy strobes, where
// resp is only meaningful in a cycle with resp_rdy=1. No back-pressure exists.
module cmd_seq_checker #(
    parameter int               DEPTH    = 8,
    parameter int               TMO_W    = 24,
    parameter logic [TMO_W-1:0] TMO_CYC  = 24'h4C4B40,
    parameter logic [7:0]       POS_ACK  = 8'hA5,
    parameter bit               CHK_RESP = 1'b1
) (
    input  logic                       clk,
    input  logic                       RST_n,
    input  logic                       ld,
    input  logic [15:0]                ld_cmd,
    input  logic                       start,
    output logic [15:0]                cmd,
    output logic                       send_cmd,
    input  logic                       cmd_sent,
    input  logic                       resp_rdy,
    input  logic [7:0]                 resp,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [1:0]                 err_code,
    output logic [$clog2(DEPTH)-1:0]   err_idx,
    output logic [$clog2(DEPTH):0]     ack_cnt,
    output logic                       ovfl,
    output logic [2:0]                 state_dbg
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] LAST_PTR = (AW+1)'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SEND      = 3'd1,
        S_WAIT_SNT  = 3'd2,
        S_WAIT_RESP = 3'd3,
        S_CHECK     = 3'd4,
        S_ERR       = 3'd5
    } state_t;

    state_t           state;
    logic [15:0]      mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      count;
    logic [TMO_W-1:0] tmr;

    logic full;
    logic do_wr;
    logic resp_ok;
    logic [AW:0] wr_ptr_nxt;
    logic [AW:0] rd_ptr_nxt;
    logic [TMO_W-1:0] tmr_inc;

    assign full       = (count == FULL_CNT);
    assign do_wr      = (state == S_IDLE) && ld && !full;
    assign resp_ok    = !CHK_RESP || (resp == POS_ACK);
    assign wr_ptr_nxt = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
    assign rd_ptr_nxt = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
    // Timer saturates rather than wrapping back to zero.
    assign tmr_inc    = (tmr == '1) ? tmr : tmr + 1'b1;
    assign state_dbg  = state;

    // Command storage; only written while idle and not full.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= ld_cmd;
    end

    // Sequencer FSM with FIFO bookkeeping and registered outputs.
    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            state    <= S_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            tmr      <= '0;
            cmd      <= '0;
            send_cmd <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_code <= 2'd0;
            err_idx  <= '0;
            ack_cnt  <= '0;
            ovfl     <= 1'b0;
        end else begin
            send_cmd <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ld) begin
                        if (full) begin
                            ovfl <= 1'b1;
                        end else begin
                            wr_ptr <= wr_ptr_nxt;
                            count  <= count + 1'b1;
                        end
                    end
                    if (start) begin
                        err_code <= 2'd0;
                        err_idx  <= '0;
                        ack_cnt  <= '0;
                        if (count != '0) begin
                            done     <= 1'b0;
                            pass     <= 1'b0;
                            cmd      <= mem[rd_ptr[AW-1:0]];
                            send_cmd <= 1'b1;
                            busy     <= 1'b1;
                            state    <= S_SEND;
                        end else begin
                            // Nothing queued: an empty sequence trivially passes.
                            done <= 1'b1;
                            pass <= 1'b1;
                        end
                    end
                end
                S_SEND: begin
                    rd_ptr <= rd_ptr_nxt;
                    count  <= count - 1'b1;
                    tmr    <= '0;
                    state  <= S_WAIT_SNT;
                end
                S_WAIT_SNT: begin
                    // A response before the send completes is a protocol error,
                    // even when cmd_sent arrives in the same cycle.
                    if (resp_rdy) begin
                        err_code <= 2'd3;
                        busy     <= 1'b0;
                        state    <= S_ERR;
                    end else if (cmd_sent) begin
                        tmr   <= '0;
                        state <= S_WAIT_RESP;
                    end else if (tmr == TMO_CYC) begin
                        err_code <= 2'd1;
                        busy     <= 1'b0;
                        state    <= S_ERR;
                    end else begin
                        tmr <= tmr_inc;
                    end
                end
                S_WAIT_RESP: begin
                    if (resp_rdy) begin
                        if (resp_ok) begin
                            state <= S_CHECK;
                        end else begin
                            err_code <= 2'd2;
                            busy     <= 1'b0;
                            state    <= S_ERR;
                        end
                    end else if (tmr == TMO_CYC) begin
                        err_code <= 2'd1;
                        busy     <= 1'b0;
                        state    <= S_ERR;
                    end else begin
                        tmr <= tmr_inc;
                    end
                end
                S_CHECK: begin
                    ack_cnt <= ack_cnt + 1'b1;
                    if (count != '0) begin
                        cmd      <= mem[rd_ptr[AW-1:0]];
                        send_cmd <= 1'b1;
                        state    <= S_SEND;
                    end else begin
                        done  <= 1'b1;
                        pass  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                S_ERR: begin
                    // ack_cnt equals the index of the command that was in flight.
                    err_idx <= ack_cnt[AW-1:0];
                    done    <= 1'b1;
                    pass    <= 1'b0;
                    count   <= '0;
                    rd_ptr  <= wr_ptr;
                    state   <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
